// File: rtl/axi_ram_sp.sv
// axi_ram_sp: AXI4 slave RAM with one single-port storage array, mapped at BASE_ADDR.
// Supports FIXED, INCR and WRAP bursts on both channels. Every beat is decoded on
// its own: an out-of-range beat gives DECERR and never touches memory. Read and
// write bursts share the one memory port, and a round-robin pointer arbitrates
// between them.
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   s_axi_aw*              write address channel (addr, len, burst, valid/ready)
//   s_axi_w*               write data channel (data, strb, last, valid/ready)
//   s_axi_b*               write response channel (resp, valid/ready)
//   s_axi_ar*              read address channel (addr, len, burst, valid/ready)
//   s_axi_r*               read data channel (data, resp, last, valid/ready)
module axi_ram_sp #(
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BYTES);
  localparam int IDX_BITS = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0]   SPAN     = (ADDR_WIDTH+1)'(DEPTH_WORDS * BYTES);
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic RR_WRITE = 1'b0;
  localparam logic RR_READ  = 1'b1;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_BURST = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} rstate_t;

  // Address of the beat that follows addr in a burst. A WRAP burst whose len
  // is not 1/3/7/15 is handled as INCR. Because len+1 is a power of two, len is
  // all ones, so the wrap mask (W-1) is simply {len, byte-offset ones}.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0] len,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    inc  = addr + STEP;
    mask = (ADDR_WIDTH'(len) << OFF_BITS) | OFF_MASK;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10: begin
        if ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15))
          next_addr = (addr & ~mask) | (inc & mask);
        else
          next_addr = inc;
      end
      default: next_addr = inc;
    endcase
  endfunction

  // Tests whether the aligned beat address lies inside the RAM window. The
  // subtraction is one bit wider so that a window at the top of the map cannot overflow.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] off;
    off      = {1'b0, addr} - {1'b0, BASE_ADDR};
    in_range = (addr >= BASE_ADDR) && (off < SPAN);
  endfunction

  function automatic logic [IDX_BITS-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    word_idx = IDX_BITS'((addr - BASE_ADDR) >> OFF_BITS);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  wstate_t               wstate_q, wstate_d;
  rstate_t               rstate_q, rstate_d;
  logic                  rr_q, rr_d;
  logic                  awready_q, awready_d;
  logic                  arready_q, arready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q;
  logic                  wready_s;

  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [7:0]            wr_len_q;
  logic [1:0]            wr_burst_q;
  logic [7:0]            wr_cnt_q;
  logic                  wr_dec_q, wr_slv_q;
  logic                  wr_dec_s, wr_slv_s;

  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [7:0]            rd_len_q;
  logic [1:0]            rd_burst_q;
  logic [7:0]            rd_cnt_q;
  logic                  rvalid_q, rlast_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_hs, ar_hs;
  logic                  wr_req, rd_req, grant_w, grant_r;
  logic                  wr_last_beat, rd_last_beat;
  logic                  wr_in_range, rd_in_range;
  logic [IDX_BITS-1:0]   wr_idx, rd_idx;

  assign aw_hs        = s_axi_awvalid && awready_q;
  assign ar_hs        = s_axi_arvalid && arready_q;
  assign wr_last_beat = (wr_cnt_q == wr_len_q);
  assign rd_last_beat = (rd_cnt_q == rd_len_q);
  assign wr_in_range  = in_range(wr_addr_q);
  assign rd_in_range  = in_range(rd_addr_q);
  assign wr_idx       = word_idx(wr_addr_q);
  assign rd_idx       = word_idx(rd_addr_q);

  // Arbitration for the single memory port. A read may only take the port when
  // its output register is free, so a stalled R channel does not block writes.
  always_comb begin
    wr_req  = (wstate_q == W_BURST) && s_axi_wvalid;
    rd_req  = (rstate_q == R_BURST) && (!rvalid_q || s_axi_rready);
    grant_w = wr_req && (!rd_req || (rr_q == RR_WRITE));
    grant_r = rd_req && (!wr_req || (rr_q == RR_READ));
    if (wr_req && rd_req)
      rr_d = grant_w ? RR_READ : RR_WRITE;
    else
      rr_d = rr_q;
  end

  // Running error flags for the write burst, including the current beat.
  always_comb begin
    wr_dec_s = wr_dec_q | !wr_in_range;
    wr_slv_s = wr_slv_q | (s_axi_wlast != wr_last_beat);
  end

  // FSM state registers, together with the registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      rr_q      <= RR_WRITE;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      rr_q      <= rr_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Next-state logic for the write and read FSMs.
  always_comb begin
    wstate_d = wstate_q;
    rstate_d = rstate_q;
    case (wstate_q)
      W_IDLE:  if (aw_hs) wstate_d = W_BURST; else wstate_d = W_IDLE;
      W_BURST: if (grant_w && wr_last_beat) wstate_d = W_RESP; else wstate_d = W_BURST;
      W_RESP:  if (s_axi_bready) wstate_d = W_IDLE; else wstate_d = W_RESP;
      default: wstate_d = W_IDLE;
    endcase
    case (rstate_q)
      R_IDLE:  if (ar_hs) rstate_d = R_BURST; else rstate_d = R_IDLE;
      R_BURST: if (grant_r && rd_last_beat) rstate_d = R_IDLE; else rstate_d = R_BURST;
      default: rstate_d = R_IDLE;
    endcase
  end

  // FSM outputs. The ready/valid flags are computed from the next state and
  // then registered. wready stays combinational because it follows arbitration.
  always_comb begin
    awready_d = (wstate_d == W_IDLE);
    arready_d = (rstate_d == R_IDLE);
    bvalid_d  = (wstate_d == W_RESP);
    wready_s  = (wstate_q == W_BURST) && !(rd_req && (rr_q == RR_READ));
  end

  // Write burst datapath: beat address, beat count and the sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q  <= '0;
      wr_len_q   <= 8'd0;
      wr_burst_q <= 2'b00;
      wr_cnt_q   <= 8'd0;
      wr_dec_q   <= 1'b0;
      wr_slv_q   <= 1'b0;
      bresp_q    <= 2'b00;
    end else if (aw_hs) begin
      wr_addr_q  <= s_axi_awaddr & ~OFF_MASK;
      wr_len_q   <= s_axi_awlen;
      wr_burst_q <= s_axi_awburst;
      wr_cnt_q   <= 8'd0;
      wr_dec_q   <= 1'b0;
      wr_slv_q   <= 1'b0;
    end else if (grant_w) begin
      wr_addr_q <= next_addr(wr_addr_q, wr_len_q, wr_burst_q);
      wr_cnt_q  <= wr_cnt_q + 8'd1;
      wr_dec_q  <= wr_dec_s;
      wr_slv_q  <= wr_slv_s;
      if (wr_last_beat)
        bresp_q <= wr_dec_s ? 2'b11 : (wr_slv_s ? 2'b10 : 2'b00);
    end
  end

  // Storage array write port, with byte enables. It has no reset, and it is
  // gated during reset so that an abandoned burst cannot write one more beat.
  always_ff @(posedge clk) begin
    if (grant_w && wr_in_range && !rst) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi_wstrb[b])
          mem_q[wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // Read burst datapath and the R output register. The payload changes only
  // when a new beat is issued, so it stays stable while the master stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q  <= '0;
      rd_len_q   <= 8'd0;
      rd_burst_q <= 2'b00;
      rd_cnt_q   <= 8'd0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
    end else begin
      if (ar_hs) begin
        rd_addr_q  <= s_axi_araddr & ~OFF_MASK;
        rd_len_q   <= s_axi_arlen;
        rd_burst_q <= s_axi_arburst;
        rd_cnt_q   <= 8'd0;
      end else if (grant_r) begin
        rd_addr_q <= next_addr(rd_addr_q, rd_len_q, rd_burst_q);
        rd_cnt_q  <= rd_cnt_q + 8'd1;
      end
      if (grant_r) begin
        rvalid_q <= 1'b1;
        rlast_q  <= rd_last_beat;
        rresp_q  <= rd_in_range ? 2'b00 : 2'b11;
        rdata_q  <= rd_in_range ? mem_q[rd_idx] : '0;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_wready  = wready_s;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_ram_sp.sv
module tb_axi_ram_sp;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  int errors = 0;
  int checks = 0;

  axi_ram_sp dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             wr;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [1:0]       burst;
    logic [7:0]       strb;
    logic [7:0]       wl;     // beat index carrying wlast (255 = never)
    logic [3:0][63:0] d;      // write data, or expected read data
    logic [1:0]       bresp;
    logic [3:0][1:0]  rresp;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [7:0] strb, input logic [7:0] wl,
                              input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                              input logic [63:0] d3, input logic [1:0] bresp, input logic [7:0] rresp);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.burst = burst; v.strb = strb; v.wl = wl;
    v.d = {d3, d2, d1, d0}; v.bresp = bresp; v.rresp = rresp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_to(input string nm, input int n);
    checks++;
    if (n >= TMO) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, expected handshake", nm, n);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [7:0][63:0] d, input logic [7:0] strb, input logic [7:0] wl,
                           output logic [1:0] resp);
    int n;
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi_awready && n < TMO) begin @(negedge clk); n++; end
    check_to("aw_hs", n);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata = d[i]; s_axi_wstrb = strb; s_axi_wlast = (i == int'(wl)); s_axi_wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_axi_wready && n < TMO) begin @(negedge clk); n++; end
      check_to("w_hs", n);
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi_bvalid && n < TMO) begin @(negedge clk); n++; end
    check_to("b_hs", n);
    resp = s_axi_bresp;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          output logic [7:0][63:0] rd, output logic [7:0][1:0] rr,
                          output logic [7:0] rl, output int lat, output int stalls);
    int n;
    rd = '0; rr = '0; rl = '0; stalls = 0; lat = 0;
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi_arready && n < TMO) begin @(negedge clk); n++; end
    check_to("ar_hs", n);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      @(negedge clk);
      while (!s_axi_rvalid && n < TMO) begin @(negedge clk); n++; end
      check_to("r_hs", n);
      if (i == 0) lat = n + 1; else stalls += n;
      rd[i] = s_axi_rdata; rr[i] = s_axi_rresp; rl[i] = s_axi_rlast;
      @(posedge clk); #1;
    end
    s_axi_rready = 1'b0;
  endtask

  task automatic recv_beat(input string nm, input logic [63:0] ed, input logic el);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_axi_rvalid && n < TMO) begin @(negedge clk); n++; end
    check_to(nm, n);
    check({nm, "_data"}, s_axi_rdata, ed);
    check({nm, "_last"}, 64'(s_axi_rlast), 64'(el));
    @(posedge clk); #1;
  endtask

  localparam int NV = 23;
  vec_t vecs [NV];

  initial begin
    logic [1:0]       resp;
    logic [7:0][63:0] rd;
    logic [7:0][1:0]  rr;
    logic [7:0]       rl;
    logic [7:0][63:0] wd;
    int               lat, stalls, wb, rb, bcyc;
    int               wcyc [8];
    int               rcyc [8];
    logic             w_hs;

    // Directed vectors; expected values are worked out from the address map by hand.
    vecs[0]  = mk(1'b1, 32'h8000_0000, 8'd3, 2'b01, 8'hFF, 8'd3, 64'h11, 64'h22, 64'h33, 64'h44, 2'b00, 8'h00);
    vecs[1]  = mk(1'b0, 32'h8000_0000, 8'd3, 2'b01, 8'hFF, 8'd3, 64'h11, 64'h22, 64'h33, 64'h44, 2'b00, 8'h00);
    vecs[2]  = mk(1'b0, 32'h8000_0010, 8'd3, 2'b10, 8'hFF, 8'd3, 64'h33, 64'h44, 64'h11, 64'h22, 2'b00, 8'h00);
    vecs[3]  = mk(1'b0, 32'h8000_0008, 8'd1, 2'b10, 8'hFF, 8'd1, 64'h22, 64'h11, 64'h0, 64'h0, 2'b00, 8'h00);
    vecs[4]  = mk(1'b0, 32'h8000_0008, 8'd2, 2'b10, 8'hFF, 8'd2, 64'h22, 64'h33, 64'h44, 64'h0, 2'b00, 8'h00);
    vecs[5]  = mk(1'b0, 32'h8000_0000, 8'd1, 2'b11, 8'hFF, 8'd1, 64'h11, 64'h22, 64'h0, 64'h0, 2'b00, 8'h00);
    vecs[6]  = mk(1'b0, 32'h8000_0008, 8'd1, 2'b00, 8'hFF, 8'd1, 64'h22, 64'h22, 64'h0, 64'h0, 2'b00, 8'h00);
    vecs[7]  = mk(1'b0, 32'h8000_0003, 8'd0, 2'b01, 8'hFF, 8'd0, 64'h11, 64'h0, 64'h0, 64'h0, 2'b00, 8'h00);
    vecs[8]  = mk(1'b1, 32'h8000_0020, 8'd0, 2'b01, 8'hFF, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h0, 2'b00, 8'h00);
    vecs[9]  = mk(1'b1, 32'h8000_0020, 8'd0, 2'b01, 8'h0F, 8'd0, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 8'h00);
    vecs[10] = mk(1'b0, 32'h8000_0020, 8'd0, 2'b01, 8'hFF, 8'd0, 64'hFFFF_FFFF_0000_0000, 64'h0, 64'h0, 64'h0, 2'b00, 8'h00);
    vecs[11] = mk(1'b1, 32'h8000_0028, 8'd2, 2'b00, 8'hFF, 8'd2, 64'hA1, 64'hA2, 64'hA3, 64'h0, 2'b00, 8'h00);
    vecs[12] = mk(1'b0, 32'h8000_0028, 8'd0, 2'b01, 8'hFF, 8'd0, 64'hA3, 64'h0, 64'h0, 64'h0, 2'b00, 8'h00);
    vecs[13] = mk(1'b1, 32'h8000_7FF8, 8'd1, 2'b01, 8'hFF, 8'd1, 64'h55, 64'h66, 64'h0, 64'h0, 2'b11, 8'h00);
    vecs[14] = mk(1'b0, 32'h8000_7FF8, 8'd1, 2'b01, 8'hFF, 8'd1, 64'h55, 64'h0, 64'h0, 64'h0, 2'b00, 8'b0000_1100);
    vecs[15] = mk(1'b0, 32'h7FFF_FFF8, 8'd0, 2'b01, 8'hFF, 8'd0, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 8'b0000_0011);
    vecs[16] = mk(1'b1, 32'h8000_0040, 8'd3, 2'b01, 8'hFF, 8'd1, 64'h1, 64'h2, 64'h3, 64'h4, 2'b10, 8'h00);
    vecs[17] = mk(1'b0, 32'h8000_0040, 8'd3, 2'b01, 8'hFF, 8'd3, 64'h1, 64'h2, 64'h3, 64'h4, 2'b00, 8'h00);
    vecs[18] = mk(1'b1, 32'h8000_0060, 8'd1, 2'b01, 8'hFF, 8'd255, 64'h7, 64'h8, 64'h0, 64'h0, 2'b10, 8'h00);
    vecs[19] = mk(1'b1, 32'h8000_8000, 8'd0, 2'b01, 8'hFF, 8'd0, 64'h9, 64'h0, 64'h0, 64'h0, 2'b11, 8'h00);
    vecs[20] = mk(1'b1, 32'h8000_0048, 8'd1, 2'b01, 8'hF0, 8'd1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'h0, 64'h0, 2'b00, 8'h00);
    vecs[21] = mk(1'b0, 32'h8000_0048, 8'd1, 2'b01, 8'hFF, 8'd1, 64'hAAAA_AAAA_0000_0002, 64'hBBBB_BBBB_0000_0003, 64'h0, 64'h0, 2'b00, 8'h00);
    vecs[22] = mk(1'b0, 32'h8000_0060, 8'd0, 2'b01, 8'hFF, 8'd0, 64'h7, 64'h0, 64'h0, 64'h0, 2'b00, 8'h00);

    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'({s_axi_awready, s_axi_arready, s_axi_wready}), 64'd0);
    check("rst_valid", 64'({s_axi_bvalid, s_axi_rvalid, s_axi_rlast}), 64'd0);
    check("rst_resp", 64'({s_axi_bresp, s_axi_rresp}), 64'd0);
    check("rst_rdata", s_axi_rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_awready_c1", 64'(s_axi_awready), 64'd0);
    @(negedge clk);
    check("rel_awready_c2", 64'(s_axi_awready), 64'd1);
    check("rel_arready_c2", 64'(s_axi_arready), 64'd1);
    @(posedge clk); #1;

    for (int k = 0; k < NV; k++) begin
      if (vecs[k].wr) begin
        axi_write(vecs[k].addr, vecs[k].len, vecs[k].burst, {256'd0, vecs[k].d},
                  vecs[k].strb, vecs[k].wl, resp);
        check($sformatf("v%0d_bresp", k), 64'(resp), 64'(vecs[k].bresp));
      end else begin
        axi_read(vecs[k].addr, vecs[k].len, vecs[k].burst, rd, rr, rl, lat, stalls);
        check($sformatf("v%0d_latency", k), 64'(lat), 64'd2);
        check($sformatf("v%0d_stalls", k), 64'(stalls), 64'd0);
        for (int i = 0; i <= int'(vecs[k].len); i++) begin
          check($sformatf("v%0d_b%0d_rdata", k, i), rd[i], vecs[k].d[i]);
          check($sformatf("v%0d_b%0d_rresp", k, i), 64'(rr[i]), 64'(vecs[k].rresp[i]));
          check($sformatf("v%0d_b%0d_rlast", k, i), 64'(rl[i]), 64'(i == int'(vecs[k].len)));
        end
      end
    end

    // Concurrent 8-beat read and write: the port must alternate, 16 beats in total.
    for (int i = 0; i < 8; i++) wd[i] = 64'hC0 + 64'(i);
    axi_write(32'h8000_0100, 8'd7, 2'b01, wd, 8'hFF, 8'd7, resp);
    check("pre_bresp", 64'(resp), 64'd0);
    s_axi_awaddr = 32'h8000_0200; s_axi_awlen = 8'd7; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    s_axi_araddr = 32'h8000_0100; s_axi_arlen = 8'd7; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    @(negedge clk);
    check("conc_aw_ar_ready", 64'({s_axi_awready, s_axi_arready}), 64'd3);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    s_axi_wvalid = 1'b1; s_axi_wdata = 64'hD0; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b0;
    wb = 0; rb = 0; bcyc = 0;
    for (int i = 0; i < 8; i++) begin wcyc[i] = 0; rcyc[i] = 0; end
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      w_hs = s_axi_wvalid && s_axi_wready;
      if (w_hs) wcyc[wb] = cyc;
      if (s_axi_rvalid && s_axi_rready && rb < 8) begin
        check("conc_rdata", s_axi_rdata, 64'hC0 + 64'(rb));
        check("conc_rlast", 64'(s_axi_rlast), 64'(rb == 7));
        rcyc[rb] = cyc;
        rb++;
      end
      if (s_axi_bvalid && bcyc == 0) begin
        bcyc = cyc;
        check("conc_bresp", 64'(s_axi_bresp), 64'd0);
      end
      @(posedge clk); #1;
      if (w_hs) begin
        wb++;
        if (wb == 8) begin
          s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        end else begin
          s_axi_wdata = 64'hD0 + 64'(wb); s_axi_wlast = (wb == 7);
        end
      end
    end
    s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    check("conc_wbeats", 64'(wb), 64'd8);
    check("conc_rbeats", 64'(rb), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("conc_wcyc%0d", i), 64'(wcyc[i]), 64'(2 * i + 1));
      check($sformatf("conc_rcyc%0d", i), 64'(rcyc[i]), 64'(2 * i + 3));
    end
    check("conc_bcyc", 64'(bcyc), 64'd16);
    axi_read(32'h8000_0200, 8'd7, 2'b01, rd, rr, rl, lat, stalls);
    for (int i = 0; i < 8; i++)
      check($sformatf("conc_readback%0d", i), rd[i], 64'hD0 + 64'(i));

    // rready low for 5 cycles mid-burst: the held beat must stay stable and no beat may be lost.
    s_axi_araddr = 32'h8000_0000; s_axi_arlen = 8'd3; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    @(negedge clk);
    check("bp_arready", 64'(s_axi_arready), 64'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    recv_beat("bp_b0", 64'h11, 1'b0);
    recv_beat("bp_b1", 64'h22, 1'b0);
    s_axi_rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(s_axi_rvalid), 64'd1);
      check("bp_hold_data", s_axi_rdata, 64'h33);
      check("bp_hold_last", 64'(s_axi_rlast), 64'd0);
      @(posedge clk); #1;
    end
    s_axi_rready = 1'b1;
    recv_beat("bp_b2", 64'h33, 1'b0);
    recv_beat("bp_b3", 64'h44, 1'b1);
    @(negedge clk);
    check("bp_no_extra", 64'(s_axi_rvalid), 64'd0);
    @(posedge clk); #1;
    s_axi_rready = 1'b0;

    // Reset in the middle of a read burst: the burst is abandoned and memory is kept.
    s_axi_araddr = 32'h8000_0100; s_axi_arlen = 8'd7; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    @(negedge clk);
    check("mr_arready", 64'(s_axi_arready), 64'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    recv_beat("mr_b0", 64'hC0, 1'b0);
    recv_beat("mr_b1", 64'hC1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mr_rvalid_c1", 64'(s_axi_rvalid), 64'd0);
    check("mr_arready_c1", 64'(s_axi_arready), 64'd0);
    @(negedge clk);
    check("mr_arready_c2", 64'(s_axi_arready), 64'd1);
    check("mr_rvalid_c2", 64'(s_axi_rvalid), 64'd0);
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    axi_read(32'h8000_0100, 8'd0, 2'b01, rd, rr, rl, lat, stalls);
    check("mr_retained", rd[0], 64'hC0);
    check("mr_retained_last", 64'(rl[0]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_ram_sp.md
Name:
axi_ram_sp
Overview:
Parametrised AXI4 slave RAM with internal single-port storage and a BASE_ADDR window. Generalises the fixed 64-bit wrapper-style RAM: FIXED/INCR/WRAP bursts on both channels, per-beat decode with DECERR/SLVERR, and round-robin read/write arbitration for the one memory port. Sits behind the crossbar as main memory or scratchpad.
Parameters:
DATA_WIDTH, 64, data bus width in bits (power of two, >=32); BYTES = DATA_WIDTH/8
ADDR_WIDTH, 32, address width
DEPTH_WORDS, 4096, number of DATA_WIDTH words (power of two)
BASE_ADDR, 32'h8000_0000, byte address of word 0 (aligned to DEPTH_WORDS*BYTES)
Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_axi_awaddr  in  ADDR_WIDTH  write burst start address
s_axi_awlen  in  8  beats minus one
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  BYTES  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_araddr  in  ADDR_WIDTH  read burst start address
s_axi_arlen  in  8  beats minus one
s_axi_arburst  in  2  as awburst
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  per-beat response, 00 OKAY or 11 DECERR
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
Behaviour:
- Reset: awready, arready, wready, bvalid, rvalid, rlast = 0; bresp, rresp, rdata = 0; both FSMs IDLE; rr pointer = write. awready/arready go 1 the cycle after rst deasserts. Memory not initialised/cleared. rst mid-burst abandons it: no B or R issued, already-written beats remain.
- Beat size is always BYTES; addresses aligned down to BYTES. Word index = (addr - BASE_ADDR) >> log2(BYTES). Beat in range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH_WORDS*BYTES, decoded per beat.
- Next address: FIXED unchanged; INCR addr+BYTES (no 4 KB check); WRAP len must be 1/3/7/15 (other lens treated as INCR), window W=(len+1)*BYTES, next = (addr & ~(W-1)) | ((addr+BYTES) & (W-1)).
- Write FSM: IDLE (awready=1) -AW hs-> BURST (wready per arbitration) -after len+1 beats-> RESP (bvalid=1, held until bready) -> IDLE, awready=1 next cycle. One outstanding write. Beat count from awlen; wstrb bytes written only, out-of-range beats dropped. bresp: DECERR if any beat out of range, else SLVERR if wlast mismatched count (early or missing), else OKAY.
- Read FSM: IDLE (arready=1) -AR hs-> BURST. Memory read issued when port granted and output register free (!rvalid || rready); rdata/rresp/rlast registered next cycle; rvalid held, payload stable until rready. Out-of-range beat: rdata=0, rresp=DECERR. After final beat issued -> IDLE, arready=1 next cycle.
- AW and AR may both be accepted the same cycle.
- Arbitration: wr_req = write BURST && wvalid; rd_req = read BURST && output free. Single request wins. Both: rr pointer holder wins, pointer flips to the loser. wready = write BURST && !(rd_req && rr==read).
- Latency: first rvalid 2 cycles after AR hs; uncontended bursts 1 beat/cycle; bvalid the cycle after last W hs; alternating contention = 1 beat/2 cycles per channel.
Test Plan:
- Write INCR len=3 at 0x8000_0000, data 0x11..0x44, wstrb=FF, then read same -> bresp=00, 4 R beats 0x11,0x22,0x33,0x44, rlast on 4th only, first rvalid 2 cycles after AR hs.
- WRAP len=3 read at 0x8000_0010 (BYTES=8) -> beats from words at 0x10,0x18,0x00,0x08.
- wstrb=0x0F onto word 0xFFFF_FFFF_FFFF_FFFF with wdata 0 -> read 0xFFFF_FFFF_0000_0000; FIXED len=2 writes -> only last beat's data remains.
- INCR len=1 read at BASE+DEPTH_WORDS*BYTES-8 -> beat0 OKAY, beat1 rdata 0 rresp=11; write same -> bresp=11, in-range beat written.
- Concurrent 8-beat read and write with rready/wvalid held high -> beats alternate, both complete, 16 port cycles; rready low 5 cycles mid-burst -> rdata stable, no beat lost.
- wlast on beat 2 of len=3 write -> bresp=10; rst asserted mid read burst -> rvalid=0 next cycle, arready=1 the cycle after rst release.
